// File: rtl/leiwand_rv32_mem_arbiter_pkg.sv
// Shared constants, state encoding and sizing helper for the two-master memory bus arbiter.
package leiwand_rv32_mem_arbiter_pkg;

    localparam int          MEM_WIDTH        = 32;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    // A disabled watchdog (limit 0) still gets a 1-bit counter so the vector stays legal.
    function automatic int wdog_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/leiwand_rv32_rr_pick.sv
// Two-way round-robin selector: on a tie the requester that was not granted last wins.
module leiwand_rv32_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_any
);

    always_comb begin
        o_any = |i_req;
        case (i_req)
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/leiwand_rv32_mem_arbiter.sv
// Round-robin arbiter sharing one memory slave between two valid/ready masters,
// with the grant held for a whole transaction and a watchdog for unacknowledged requests.
//   state   | meaning
//   IDLE    | no grant, all slave and response outputs 0, arbitrate pending requests
//   GNT0    | master 0 owns the slave bus until ready, timeout or valid drop
//   GNT1    | master 1 owns the slave bus until ready, timeout or valid drop
module leiwand_rv32_mem_arbiter
    import leiwand_rv32_mem_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = MEM_WIDTH,
    parameter int                    DATA_WIDTH     = MEM_WIDTH,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_m0_valid,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    input  logic [3:0]            i_m0_wen,
    output logic                  o_m0_ready,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    input  logic                  i_m1_valid,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    input  logic [3:0]            i_m1_wen,
    output logic                  o_m1_ready,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic                  o_s_valid,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [DATA_WIDTH-1:0] o_s_wdata,
    output logic [3:0]            o_s_wen,
    input  logic                  i_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_rdata,
    output logic                  o_bus_err
);

    localparam int              WDOG_W   = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);
    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_last_grant;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_bus_err;

    logic w_pick;
    logic w_any;
    logic w_granted;
    logic w_gnt_idx;
    logic w_mvalid;
    logic w_timeout;

    leiwand_rv32_rr_pick u_rr_pick (
        .i_req        ({i_m1_valid, i_m0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_any        (w_any)
    );

    assign w_granted = (r_state != ST_IDLE);
    assign w_gnt_idx = (r_state == ST_GNT1);
    assign w_mvalid  = w_gnt_idx ? i_m1_valid : i_m0_valid;
    // A slave ready in the limit cycle still wins; a master that already dropped valid gets no error.
    assign w_timeout = WDOG_EN && w_granted && w_mvalid && !i_s_ready && (r_wdog == WDOG_MAX);
    assign o_bus_err = r_bus_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_wdog       <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_granted && (i_s_ready || w_timeout)) begin
                r_last_grant <= w_gnt_idx;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
            if (w_granted && (w_state_next != ST_IDLE)) begin
                if (r_wdog != WDOG_MAX) begin
                    r_wdog <= r_wdog + WDOG_W'(1);
                end
            end else begin
                r_wdog <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = w_pick ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (i_s_ready || !w_mvalid || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_s_valid  = 1'b0;
        o_s_addr   = '0;
        o_s_wdata  = '0;
        o_s_wen    = '0;
        o_m0_ready = 1'b0;
        o_m0_rdata = '0;
        o_m1_ready = 1'b0;
        o_m1_rdata = '0;
        case (r_state)
            ST_GNT0: begin
                o_s_valid  = i_m0_valid && !w_timeout;
                o_s_addr   = i_m0_addr;
                o_s_wdata  = i_m0_wdata;
                o_s_wen    = i_m0_wen;
                o_m0_ready = i_s_ready || w_timeout;
                o_m0_rdata = w_timeout ? ERR_DATA : i_s_rdata;
            end
            ST_GNT1: begin
                o_s_valid  = i_m1_valid && !w_timeout;
                o_s_addr   = i_m1_addr;
                o_s_wdata  = i_m1_wdata;
                o_s_wen    = i_m1_wen;
                o_m1_ready = i_s_ready || w_timeout;
                o_m1_rdata = w_timeout ? ERR_DATA : i_s_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// Bench for the memory arbiter: transaction-level reference model checked every cycle,
// a small registered memory slave, and directed scenarios with literal expectations.
module tb_leiwand_rv32_mem_arbiter;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mv [2];
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic [3:0]  mw [2];

    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wen;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        bus_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [31:0] mem [16];
    bit          slave_en;
    int          slave_lat = 1;
    int          scnt;

    int          order [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    leiwand_rv32_mem_arbiter #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_m0_valid (mv[0]),
        .i_m0_addr  (ma[0]),
        .i_m0_wdata (md[0]),
        .i_m0_wen   (mw[0]),
        .o_m0_ready (m0_ready),
        .o_m0_rdata (m0_rdata),
        .i_m1_valid (mv[1]),
        .i_m1_addr  (ma[1]),
        .i_m1_wdata (md[1]),
        .i_m1_wen   (mw[1]),
        .o_m1_ready (m1_ready),
        .o_m1_rdata (m1_rdata),
        .o_s_valid  (s_valid),
        .o_s_addr   (s_addr),
        .o_s_wdata  (s_wdata),
        .o_s_wen    (s_wen),
        .i_s_ready  (s_ready),
        .i_s_rdata  (s_rdata),
        .o_bus_err  (bus_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory slave: acknowledges slave_lat cycles after it first sees s_valid.
    always @(posedge clk) begin
        if (rst) begin
            s_ready <= 1'b0;
            s_rdata <= '0;
            scnt    <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
            mem[1] <= 32'h0000_0013;
        end else if (s_ready) begin
            s_ready <= 1'b0;
            s_rdata <= '0;
            scnt    <= 0;
        end else if (s_valid && slave_en) begin
            if (scnt + 1 >= slave_lat) begin
                s_ready <= 1'b1;
                s_rdata <= mem[s_addr[5:2]];
                for (int b = 0; b < 4; b++)
                    if (s_wen[b]) mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end else begin
                scnt <= scnt + 1;
            end
        end else begin
            scnt <= 0;
        end
    end

    // Reference model: who owns the bus, how long it has owned it, who was served last.
    int          owner = -1;
    int          age   = 0;
    int          last  = 1;
    bit          err   = 1'b0;
    bit          mdl_ok = 1'b0;
    bit          x_sv, x_to, x_v;
    logic [31:0] x_sa, x_sd;
    logic [3:0]  x_sw;
    logic [1:0]  x_r;
    logic [31:0] x_rd [2];

    always @(negedge clk) begin
        x_sv = 1'b0; x_sa = '0; x_sd = '0; x_sw = '0; x_r = '0;
        x_rd[0] = '0; x_rd[1] = '0;
        x_to = 1'b0; x_v = 1'b0;
        if (owner >= 0) begin
            x_v  = mv[owner];
            x_to = x_v && !s_ready && (age == TMO);
            x_sv = x_v && !x_to;
            x_sa = ma[owner];
            x_sd = md[owner];
            x_sw = mw[owner];
            x_r[owner]  = x_to || s_ready;
            x_rd[owner] = x_to ? ERR : s_rdata;
        end
        if (mdl_ok) begin
            chk("s_valid",  32'(s_valid),  32'(x_sv));
            chk("s_addr",   s_addr,        x_sa);
            chk("s_wdata",  s_wdata,       x_sd);
            chk("s_wen",    32'(s_wen),    32'(x_sw));
            chk("m0_ready", 32'(m0_ready), 32'(x_r[0]));
            chk("m1_ready", 32'(m1_ready), 32'(x_r[1]));
            chk("m0_rdata", m0_rdata,      x_rd[0]);
            chk("m1_rdata", m1_rdata,      x_rd[1]);
            chk("bus_err",  32'(bus_err),  32'(err));
        end
        if (rst) begin
            owner = -1; age = 0; last = 1; err = 1'b0; mdl_ok = 1'b1;
        end else if (mdl_ok) begin
            if (owner < 0) begin
                age = 0;
                if (mv[0] && mv[1]) owner = 1 - last;
                else if (mv[0])     owner = 0;
                else if (mv[1])     owner = 1;
            end else if (s_ready || !x_v || x_to) begin
                if (s_ready || x_to) last = owner;
                if (x_to) err = 1'b1;
                owner = -1;
                age   = 0;
            end else begin
                age++;
            end
        end
    end

    function automatic logic get_ready(input int idx);
        return (idx == 1) ? m1_ready : m0_ready;
    endfunction

    // Raise a request on the next cycle and return in the cycle its ready is seen.
    task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] w, output logic [31:0] rd, output int lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        mv[idx] = 1'b1; ma[idx] = a; md[idx] = d; mw[idx] = w;
        t0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (get_ready(idx)) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL txn_wait m%0d: got no ready, expected ready within 50 cycles", idx);
        end
        rd  = (idx == 1) ? m1_rdata : m0_rdata;
        lat = cyc - t0;
        order.push_back(idx);
    endtask

    task automatic mrelease(input int idx);
        @(posedge clk); #1;
        mv[idx] = 1'b0;
    endtask

    task automatic tie_pair(output int first);
        logic [31:0] r0, r1;
        int l0, l1;
        order.delete();
        fork
            begin do_txn(0, 32'h24, 32'h0, 4'h0, r0, l0); mrelease(0); end
            begin do_txn(1, 32'h28, 32'h0, 4'h0, r1, l1); mrelease(1); end
        join
        chk("tie_m0_rdata", r0, 32'h1000_0009);
        chk("tie_m1_rdata", r1, 32'h1000_000A);
        first = (order.size() > 0) ? order[0] : -1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          first;
        int          exp_ord [4];
        exp_ord = '{0, 1, 0, 1};

        rst = 1'b1; slave_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; ma[i] = '0; md[i] = '0; mw[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_valid",  32'(s_valid),  32'h0);
        chk("rst_m0_ready", 32'(m0_ready), 32'h0);
        chk("rst_bus_err",  32'(bus_err),  32'h0);

        // single master read
        do_txn(0, 32'h4, 32'h0, 4'h0, rd, lat);
        chk("single_rdata", rd, 32'h0000_0013);
        chk("single_lat", lat, 2);
        mrelease(0);

        // tie straight after reset, both masters keep requesting
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        order.delete();
        fork
            begin
                do_txn(0, 32'h0, 32'h0, 4'h0, rd, lat);
                chk("rr_m0_a_rdata", rd, 32'h1000_0000);
                do_txn(0, 32'hC, 32'h0, 4'h0, rd, lat);
                chk("rr_m0_b_rdata", rd, 32'h1000_0003);
                mrelease(0);
            end
            begin
                logic [31:0] rd1;
                int          lat1;
                do_txn(1, 32'h20, 32'h0, 4'h0, rd1, lat1);
                chk("rr_m1_a_rdata", rd1, 32'h1000_0008);
                do_txn(1, 32'h24, 32'h0, 4'h0, rd1, lat1);
                chk("rr_m1_b_rdata", rd1, 32'h1000_0009);
                mrelease(1);
            end
        join
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("rr_order", order[i], exp_ord[i]);

        // write routing through m1
        do_txn(1, 32'h8, 32'hCAFE_F00D, 4'b1111, rd, lat);
        chk("write_mem2", mem[2], 32'hCAFE_F00D);
        chk("write_lat", lat, 2);
        mrelease(1);

        // m0 read so that m0 is the last granted master
        do_txn(0, 32'h10, 32'h0, 4'h0, rd, lat);
        chk("pre_viol_rdata", rd, 32'h1000_0004);
        mrelease(0);

        // m1 abandons its request while granted
        slave_en = 1'b0;
        @(posedge clk); #1 mv[1] = 1'b1; ma[1] = 32'h30; md[1] = '0; mw[1] = '0;
        @(posedge clk); #1;
        @(posedge clk); #1 mv[1] = 1'b0;
        @(negedge clk);
        chk("viol_s_valid", 32'(s_valid), 32'h0);
        slave_en = 1'b1;
        tie_pair(first);
        chk("viol_tie_first", first, 1);

        // reset in the middle of a GNT0 transaction
        slave_en = 1'b0;
        @(posedge clk); #1 mv[0] = 1'b1; ma[0] = 32'h14;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; mv[0] = 1'b0;
        @(negedge clk);
        chk("rstmid_s_valid",  32'(s_valid),  32'h0);
        chk("rstmid_s_addr",   s_addr,        32'h0);
        chk("rstmid_m0_ready", 32'(m0_ready), 32'h0);
        slave_en = 1'b1;
        tie_pair(first);
        chk("rstmid_tie_first", first, 0);

        // watchdog with a silent slave
        slave_en = 1'b0;
        do_txn(0, 32'h18, 32'h0, 4'h0, rd, lat);
        chk("wdog_rdata", rd, 32'hDEAD_BEEF);
        chk("wdog_lat", lat, 1 + TMO);
        mrelease(0);
        @(negedge clk);
        chk("wdog_bus_err", 32'(bus_err), 32'h1);
        repeat (3) @(negedge clk);
        chk("wdog_bus_err_sticky", 32'(bus_err), 32'h1);
        slave_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("wdog_bus_err_cleared", 32'(bus_err), 32'h0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
